// File: rtl/mmu_feeder_pkg.sv
// mmu_feeder_pkg: shared definitions for the MMU feeder and the MMU output-side blocks.
//   feeder_state_t    : feeder FSM state encoding
//   DEFAULT_DEPTH     : default array lanes / tile rows
//   DEFAULT_BIT_WIDTH : default operand width per lane
//   cnt_width()       : counter width for values 0..n-1 (never below 1 bit)
package mmu_feeder_pkg;

  localparam int DEFAULT_DEPTH     = 4;
  localparam int DEFAULT_BIT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } feeder_state_t;

  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mmu_feeder_if.sv
// mmu_feeder_if: row-load handshake plus skewed array-side outputs of the feeder.
//   in_valid / in_ready : row handshake (source -> feeder)
//   data_vec / wt_vec   : one data row and one weight row, lane i at [i*bit_width +: bit_width]
//   data_arr / wt_arr   : skewed operands to the systolic array
//   control             : array enable, high on every stream cycle
//   busy / done         : feeder not idle / one-cycle end-of-tile pulse
// master = row source (testbench / upstream), slave = feeder.
interface mmu_feeder_if #(
  parameter int depth     = mmu_feeder_pkg::DEFAULT_DEPTH,
  parameter int bit_width = mmu_feeder_pkg::DEFAULT_BIT_WIDTH
);

  logic                         in_valid;
  logic                         in_ready;
  logic [depth*bit_width-1:0]   data_vec;
  logic [depth*bit_width-1:0]   wt_vec;
  logic [depth*bit_width-1:0]   data_arr;
  logic [depth*bit_width-1:0]   wt_arr;
  logic                         control;
  logic                         busy;
  logic                         done;

  modport master (
    output in_valid, data_vec, wt_vec,
    input  in_ready, data_arr, wt_arr, control, busy, done
  );

  modport slave (
    input  in_valid, data_vec, wt_vec,
    output in_ready, data_arr, wt_arr, control, busy, done
  );

endinterface

// File: rtl/mmu_feeder_skew_lane.sv
// skew_lane: picks one lane's operand for stream step t.
//   i_col  : this lane's element from every buffered row (index = row)
//   i_t    : stream step
//   o_elem : i_col[t - lane] when 0 <= t - lane < depth, else zero
module skew_lane
  import mmu_feeder_pkg::*;
#(
  parameter int depth     = DEFAULT_DEPTH,
  parameter int bit_width = DEFAULT_BIT_WIDTH,
  parameter int lane      = 0,
  parameter int t_w       = 3
) (
  input  logic [depth-1:0][bit_width-1:0] i_col,
  input  logic [t_w-1:0]                  i_t,
  output logic [bit_width-1:0]            o_elem
);

  // OR-select: at most one row matches t - lane, so no priority is needed
  always_comb begin
    o_elem = '0;
    for (int r = 0; r < depth; r++) begin
      o_elem = o_elem | ({bit_width{(32'(i_t) == 32'(r + lane))}} & i_col[r]);
    end
  end

endmodule

// File: rtl/mmu_feeder.sv
// mmu_feeder: buffers a depth x depth tile of data and weight rows, then streams
// them diagonally skewed into a systolic array over 2*depth-1 cycles.
//   clk   : clock, all state on posedge
//   reset : asynchronous, active-high
//   bus   : mmu_feeder_if.slave (row handshake in, skewed operands / status out)
module mmu_feeder
  import mmu_feeder_pkg::*;
#(
  parameter int depth     = DEFAULT_DEPTH,
  parameter int bit_width = DEFAULT_BIT_WIDTH
) (
  input  logic         clk,
  input  logic         reset,
  mmu_feeder_if.slave  bus
);

  localparam int ROW_W = depth * bit_width;
  localparam int CNT_W = cnt_width(depth);
  localparam int T_W   = cnt_width(2 * depth - 1);
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(depth - 1);
  localparam logic [T_W-1:0]   T_LAST   = T_W'(2 * depth - 2);

  feeder_state_t               r_state;
  feeder_state_t               w_state_nxt;
  logic [CNT_W-1:0]            r_row_cnt;
  logic [CNT_W-1:0]            w_row_cnt_nxt;
  logic [CNT_W-1:0]            w_wr_idx;
  logic [T_W-1:0]              r_t;
  logic [T_W-1:0]              w_t_nxt;
  logic                        w_in_ready;
  logic                        w_hs;
  logic                        w_last_row;
  logic [depth-1:0][ROW_W-1:0] r_data_buf;
  logic [depth-1:0][ROW_W-1:0] r_wt_buf;
  logic [ROW_W-1:0]            w_data_skew;
  logic [ROW_W-1:0]            w_wt_skew;
  logic [ROW_W-1:0]            r_data_arr;
  logic [ROW_W-1:0]            r_wt_arr;
  logic                        r_control;
  logic                        r_busy;
  logic                        r_done;

  assign w_hs       = bus.in_valid & w_in_ready;
  assign w_last_row = (w_wr_idx == LAST_ROW);

  // Handshake-side decode: ready in IDLE/LOAD, write index restarts at row 0 from IDLE
  always_comb begin
    w_in_ready = 1'b0;
    w_wr_idx   = r_row_cnt;
    case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        w_wr_idx   = '0;
      end
      LOAD: begin
        w_in_ready = 1'b1;
        w_wr_idx   = r_row_cnt;
      end
      STREAM, DONE: begin
        w_in_ready = 1'b0;
        w_wr_idx   = r_row_cnt;
      end
      default: begin
        w_in_ready = 1'b0;
        w_wr_idx   = '0;
      end
    endcase
  end

  // Next-state logic for FSM, row counter and stream step
  always_comb begin
    w_state_nxt   = r_state;
    w_row_cnt_nxt = r_row_cnt;
    w_t_nxt       = '0;
    case (r_state)
      IDLE, LOAD: begin
        if (w_hs) begin
          if (w_last_row) begin
            w_state_nxt   = STREAM;
            w_row_cnt_nxt = '0;
          end else begin
            w_state_nxt   = LOAD;
            w_row_cnt_nxt = w_wr_idx + CNT_W'(1);
          end
        end else begin
          w_state_nxt   = r_state;
          w_row_cnt_nxt = r_row_cnt;
        end
      end
      STREAM: begin
        if (r_t == T_LAST) begin
          w_state_nxt = DONE;
          w_t_nxt     = '0;
        end else begin
          w_state_nxt = STREAM;
          w_t_nxt     = r_t + T_W'(1);
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt   = IDLE;
        w_row_cnt_nxt = '0;
      end
    endcase
  end

  // FSM state, row counter and stream step registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_row_cnt <= '0;
      r_t       <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_row_cnt <= w_row_cnt_nxt;
      r_t       <= w_t_nxt;
    end
  end

  // Row buffers: written only on a handshake, contents survive reset
  always_ff @(posedge clk) begin
    for (int r = 0; r < depth; r++) begin
      if (w_hs && (w_wr_idx == CNT_W'(r))) begin
        r_data_buf[r] <= bus.data_vec;
        r_wt_buf[r]   <= bus.wt_vec;
      end
    end
  end

  // Skew selection is fed the *next* step so the registered outputs line up with
  // STREAM; at step 0 only row 0 is read, which was stored on an earlier handshake.
  for (genvar i = 0; i < depth; i++) begin : g_lane
    logic [depth-1:0][bit_width-1:0] w_data_col;
    logic [depth-1:0][bit_width-1:0] w_wt_col;

    // Gather lane i of every buffered row
    always_comb begin
      w_data_col = '0;
      w_wt_col   = '0;
      for (int r = 0; r < depth; r++) begin
        w_data_col[r] = r_data_buf[r][i*bit_width +: bit_width];
        w_wt_col[r]   = r_wt_buf[r][i*bit_width +: bit_width];
      end
    end

    skew_lane #(
      .depth     (depth),
      .bit_width (bit_width),
      .lane      (i),
      .t_w       (T_W)
    ) u_data_lane (
      .i_col  (w_data_col),
      .i_t    (w_t_nxt),
      .o_elem (w_data_skew[i*bit_width +: bit_width])
    );

    skew_lane #(
      .depth     (depth),
      .bit_width (bit_width),
      .lane      (i),
      .t_w       (T_W)
    ) u_wt_lane (
      .i_col  (w_wt_col),
      .i_t    (w_t_nxt),
      .o_elem (w_wt_skew[i*bit_width +: bit_width])
    );
  end

  // Registered outputs, decoded from the state being entered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data_arr <= '0;
      r_wt_arr   <= '0;
      r_control  <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_data_arr <= (w_state_nxt == STREAM) ? w_data_skew : '0;
      r_wt_arr   <= (w_state_nxt == STREAM) ? w_wt_skew : '0;
      r_control  <= (w_state_nxt == STREAM);
      r_busy     <= (w_state_nxt != IDLE);
      r_done     <= (w_state_nxt == DONE);
    end
  end

  assign bus.in_ready = w_in_ready;
  assign bus.data_arr = r_data_arr;
  assign bus.wt_arr   = r_wt_arr;
  assign bus.control  = r_control;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;

endmodule

// File: tb/tb_mmu_feeder.sv
// tb_mmu_feeder: directed self-checking bench for mmu_feeder (depth 4, 8-bit lanes).
module tb_mmu_feeder;
  import mmu_feeder_pkg::*;

  localparam int D  = 4;
  localparam int BW = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mmu_feeder_if #(.depth(D), .bit_width(BW)) bus();

  mmu_feeder #(.depth(D), .bit_width(BW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] t1_data [4] = '{32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D};
  logic [31:0] t1_wt   [4] = '{32'h11111111, 32'h11111111, 32'h11111111, 32'h11111111};
  logic [31:0] t2_data [4] = '{32'h13121110, 32'h23222120, 32'h33323130, 32'h43424140};

  // Hand-derived skewed streams, index = stream step t
  logic [31:0] exp_t1  [7] = '{32'h00000001, 32'h00000205, 32'h00030609, 32'h04070A0D,
                               32'h080B0E00, 32'h0C0F0000, 32'h10000000};
  logic [31:0] exp_w11 [7] = '{32'h00000011, 32'h00001111, 32'h00111111, 32'h11111111,
                               32'h11111100, 32'h11110000, 32'h11000000};
  logic [31:0] exp_t2  [7] = '{32'h00000010, 32'h00001120, 32'h00122130, 32'h13223140,
                               32'h23324100, 32'h33420000, 32'h43000000};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_tile(input string tag, input logic [31:0] d [4], input logic [31:0] w [4]);
    for (int r = 0; r < 4; r++) begin
      bus.in_valid = 1'b1;
      bus.data_vec = d[r];
      bus.wt_vec   = w[r];
      check($sformatf("%s_ready%0d", tag, r), bus.in_ready, 1);
      tick();
    end
    bus.in_valid = 1'b0;
  endtask

  // Expects to be entered on stream step 0; leaves the bench in the DONE cycle
  task automatic stream_check(input string tag, input logic [31:0] ed [7], input logic [31:0] ew [7]);
    for (int k = 0; k < 7; k++) begin
      check($sformatf("%s_data_t%0d", tag, k), bus.data_arr, ed[k]);
      check($sformatf("%s_wt_t%0d", tag, k), bus.wt_arr, ew[k]);
      check($sformatf("%s_ctrl_t%0d", tag, k), bus.control, 1);
      check($sformatf("%s_done_t%0d", tag, k), bus.done, 0);
      check($sformatf("%s_ready_t%0d", tag, k), bus.in_ready, 0);
      check($sformatf("%s_busy_t%0d", tag, k), bus.busy, 1);
      tick();
    end
    check({tag, "_done_pulse"}, bus.done, 1);
    check({tag, "_done_ctrl"}, bus.control, 0);
    check({tag, "_done_data"}, bus.data_arr, 0);
    check({tag, "_done_wt"}, bus.wt_arr, 0);
    check({tag, "_done_ready"}, bus.in_ready, 0);
    check({tag, "_done_busy"}, bus.busy, 1);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_idle_done"}, bus.done, 0);
    check({tag, "_idle_busy"}, bus.busy, 0);
    check({tag, "_idle_ready"}, bus.in_ready, 1);
    check({tag, "_idle_ctrl"}, bus.control, 0);
    check({tag, "_idle_data"}, bus.data_arr, 0);
  endtask

  initial begin
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.data_vec = '0;
    bus.wt_vec   = '0;

    // Reset state
    #2;
    check("rst_ready", bus.in_ready, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_ctrl", bus.control, 0);
    check("rst_done", bus.done, 0);
    check("rst_data", bus.data_arr, 0);
    check("rst_wt", bus.wt_arr, 0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    check_idle("post_rst");

    // Basic skew of data and weights
    load_tile("t1", t1_data, t1_wt);
    stream_check("t1", exp_t1, exp_w11);
    tick();
    check_idle("t1");

    // Stalled load after row 1
    for (int r = 0; r < 2; r++) begin
      bus.in_valid = 1'b1;
      bus.data_vec = t1_data[r];
      bus.wt_vec   = t1_wt[r];
      tick();
    end
    bus.in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("stall_ready%0d", k), bus.in_ready, 1);
      check($sformatf("stall_rowcnt%0d", k), dut.r_row_cnt, 2);
      check($sformatf("stall_busy%0d", k), bus.busy, 1);
      check($sformatf("stall_ctrl%0d", k), bus.control, 0);
      tick();
    end
    for (int r = 2; r < 4; r++) begin
      bus.in_valid = 1'b1;
      bus.data_vec = t1_data[r];
      bus.wt_vec   = t1_wt[r];
      check($sformatf("stall_ready_row%0d", r), bus.in_ready, 1);
      tick();
    end
    bus.in_valid = 1'b0;
    stream_check("stall", exp_t1, exp_w11);
    tick();
    check_idle("stall");

    // Back-to-back tiles with in_valid held high through STREAM/DONE
    load_tile("b2b1", t1_data, t1_wt);
    bus.in_valid = 1'b1;
    bus.data_vec = t2_data[0];
    bus.wt_vec   = t1_data[0];
    stream_check("b2b1", exp_t1, exp_w11);
    tick();
    check_idle("b2b_gap");
    tick();
    check("b2b_row0_taken", dut.r_row_cnt, 1);
    check("b2b_busy_load", bus.busy, 1);
    for (int r = 1; r < 4; r++) begin
      bus.data_vec = t2_data[r];
      bus.wt_vec   = t1_data[r];
      check($sformatf("b2b_ready_row%0d", r), bus.in_ready, 1);
      tick();
    end
    bus.in_valid = 1'b0;
    stream_check("b2b2", exp_t2, exp_t1);
    tick();
    check_idle("b2b2");

    // Asynchronous reset at stream step 2
    load_tile("rs", t1_data, t1_wt);
    check("rs_data_t0", bus.data_arr, exp_t1[0]);
    tick();
    check("rs_data_t1", bus.data_arr, exp_t1[1]);
    tick();
    check("rs_data_t2", bus.data_arr, exp_t1[2]);
    check("rs_ctrl_t2", bus.control, 1);
    reset = 1'b1;
    #1;
    check("rs_async_data", bus.data_arr, 0);
    check("rs_async_wt", bus.wt_arr, 0);
    check("rs_async_ctrl", bus.control, 0);
    check("rs_async_done", bus.done, 0);
    check("rs_async_busy", bus.busy, 0);
    check("rs_async_ready", bus.in_ready, 1);
    check("rs_async_state", dut.r_state, IDLE);
    tick();
    reset = 1'b0;
    tick();
    check_idle("rs_release");
    load_tile("rs2", t2_data, t1_data);
    stream_check("rs2", exp_t2, exp_t1);
    tick();
    check_idle("rs2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mmu_feeder.md
MMU_FEEDER -- requirements
Module: mmu_feeder

Interface
REQ-001 SHALL have parameter depth, default 4, meaning array lanes and tile rows.
REQ-002 SHALL have parameter bit_width, default 8, meaning operand width per lane.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state updates on posedge.
REQ-004 SHALL have port reset, input, 1, meaning reset, asynchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1, meaning a tile row pair is presented.
REQ-006 SHALL have port in_ready, output, 1, meaning the feeder accepts a row this cycle.
REQ-007 SHALL have port data_vec, input, bit_width*depth, meaning one data row, lane i at bits [i*bit_width +: bit_width].
REQ-008 SHALL have port wt_vec, input, bit_width*depth, meaning one weight row, same lane packing.
REQ-009 SHALL have port data_arr, output, bit_width*depth, meaning skewed data to the systolic array.
REQ-010 SHALL have port wt_arr, output, bit_width*depth, meaning skewed weights to the systolic array.
REQ-011 SHALL have port control, output, 1, meaning array enable, high for every stream cycle.
REQ-012 SHALL have port busy, output, 1, meaning the FSM is not in IDLE.
REQ-013 SHALL have port done, output, 1, meaning one-cycle pulse after the last stream cycle.

Function
REQ-014 SHALL implement FSM states IDLE, LOAD, STREAM, DONE.
REQ-015 IDLE: in_ready=1; a handshake (in_valid & in_ready) stores row 0 and moves to LOAD.
REQ-016 LOAD: in_ready=1; each handshake stores the next row at index row_cnt; the handshake of row depth-1 moves to STREAM.
REQ-017 LOAD with in_valid=0 SHALL hold state and row_cnt indefinitely; there is no timeout.
REQ-018 STREAM and DONE: in_ready=0; in_valid is ignored and no buffer write occurs.
REQ-019 STREAM SHALL last exactly 2*depth-1 cycles, counted by t = 0 .. 2*depth-2.
REQ-020 At stream cycle t, lane i of data_arr SHALL be data_buf[t-i][i] if 0 <= t-i < depth, else zero.
REQ-021 wt_arr SHALL follow the same rule on wt_buf.
REQ-022 data_arr, wt_arr and control SHALL be registered; the first skewed value appears the cycle after the final load handshake.
REQ-023 Outside STREAM, data_arr and wt_arr SHALL be zero and control SHALL be 0.
REQ-024 After t = 2*depth-2, the FSM SHALL enter DONE for one cycle with done=1, then return to IDLE.
REQ-025 Back-to-back tiles: a handshake in the IDLE cycle after DONE SHALL be accepted; minimum tile period is depth + 2*depth-1 + 1 cycles.
REQ-026 Operands pass unmodified; no arithmetic and no width change.

Reset
REQ-027 Asserting reset SHALL immediately force IDLE, row_cnt=0, t=0, and data_arr=0, wt_arr=0, control=0, done=0, busy=0.
REQ-028 in_ready SHALL read 1 during and after reset, since IDLE drives it.
REQ-029 Buffer contents need not be cleared; a reset mid-LOAD or mid-STREAM SHALL discard the partial tile.
REQ-030 The first tile after reset release SHALL be loaded from row 0.

Structure
REQ-031 A shared package SHALL hold the FSM state enum (feeder_state_t) and default depth and bit_width constants, for reuse by the MMU output-side blocks.
REQ-032 One sub-module, skew_lane, SHALL select lane i's element from the row buffer given t; it SHALL be instantiated twice per lane (data and weight) via generate.

Verification
REQ-033 Skew: load data rows 0x04030201, 0x08070605, 0x0C0B0A09, 0x100F0E0D -> data_arr = 0x00000001, 0x00000205, then 0x04070A0D at t=3, and 0x10000000 at t=6; control high for exactly 7 cycles.
REQ-034 Weights: load wt rows all 0x11111111 -> wt_arr at t=0 is 0x00000011, at t=3 is 0x11111111, and at t=6 is 0x11000000.
REQ-035 Stalled load: drop in_valid for 5 cycles after row 1 -> row_cnt holds, in_ready stays 1, and the stream output is identical to REQ-033.
REQ-036 Back-to-back: a second tile is presented immediately -> in_ready=0 through STREAM/DONE, the first row is accepted the cycle after done, and both tiles stream correctly.
REQ-037 Reset at t=2 -> all outputs 0 in the same cycle and the FSM is in IDLE; a fresh tile afterwards streams correctly from row 0.
REQ-038 in_valid held high during STREAM -> no buffer corruption (the current tile's outputs are unchanged) and done pulses exactly once.
